// File: rtl/convolution_procesor_tap_line.sv
// Multi-stage sample shift line with parallel tap access, fill counter and window-valid strobe.
// Optional circular rotate on shift is enabled by defining CONV_TAPLINE_ROTATE_EN.
module convolution_procesor_tap_line #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 4,
    localparam int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        clrh,
    input  logic                        shift_en,
    input  logic                        ld,
`ifdef CONV_TAPLINE_ROTATE_EN
    input  logic                        rot_en,
`endif
    input  logic [DATA_WIDTH-1:0]       data_i,
    input  logic [DATA_WIDTH*DEPTH-1:0] ld_data_i,
    output logic [DATA_WIDTH*DEPTH-1:0] taps_o,
    output logic [DATA_WIDTH-1:0]       data_o,
    output logic [CNT_WIDTH-1:0]        count_o,
    output logic                        full_o,
    output logic                        valid_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] stage [DEPTH];
    logic [CNT_WIDTH-1:0]  count;
    logic                  valid;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        if (c == CNT_FULL) begin
            return c;
        end
        return c + 1'b1;
    endfunction

    // Priority: ld > shift_en > clrh > hold.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage[k] <= '0;
            end
            count <= '0;
            valid <= 1'b0;
        end else if (ld) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage[k] <= ld_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
            count <= CNT_FULL;
            valid <= 1'b1;
        end else if (shift_en) begin
            for (int k = 1; k < DEPTH; k++) begin
                stage[k] <= stage[k-1];
            end
`ifdef CONV_TAPLINE_ROTATE_EN
            if (rot_en) begin
                stage[0] <= stage[DEPTH-1];
                valid    <= (count == CNT_FULL);
            end else begin
                stage[0] <= data_i;
                count    <= sat_inc(count);
                valid    <= (sat_inc(count) == CNT_FULL);
            end
`else
            stage[0] <= data_i;
            count    <= sat_inc(count);
            valid    <= (sat_inc(count) == CNT_FULL);
`endif
        end else if (clrh) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage[k] <= '0;
            end
            count <= '0;
            valid <= 1'b0;
        end else begin
            valid <= 1'b0;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_taps
        assign taps_o[g*DATA_WIDTH +: DATA_WIDTH] = stage[g];
    end

    assign data_o  = stage[DEPTH-1];
    assign count_o = count;
    assign full_o  = (count == CNT_FULL);
    assign valid_o = valid;

endmodule

// File: tb/tb_convolution_procesor_tap_line.sv
// Directed-vector bench for convolution_procesor_tap_line at DATA_WIDTH=8, DEPTH=3.
// Rotate vectors run only when CONV_TAPLINE_ROTATE_EN is defined.
module tb_convolution_procesor_tap_line;

    localparam int DW = 8;
    localparam int DP = 3;
    localparam int CW = $clog2(DP + 1);

    logic           clk = 1'b0;
    logic           rstn;
    logic           clrh;
    logic           shift_en;
    logic           ld;
`ifdef CONV_TAPLINE_ROTATE_EN
    logic           rot_en;
`endif
    logic [DW-1:0]    data_i;
    logic [DW*DP-1:0] ld_data_i;
    logic [DW*DP-1:0] taps_o;
    logic [DW-1:0]    data_o;
    logic [CW-1:0]    count_o;
    logic             full_o;
    logic             valid_o;

    int total = 0;
    int bad   = 0;

    convolution_procesor_tap_line #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .clrh      (clrh),
        .shift_en  (shift_en),
        .ld        (ld),
`ifdef CONV_TAPLINE_ROTATE_EN
        .rot_en    (rot_en),
`endif
        .data_i    (data_i),
        .ld_data_i (ld_data_i),
        .taps_o    (taps_o),
        .data_o    (data_o),
        .count_o   (count_o),
        .full_o    (full_o),
        .valid_o   (valid_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of controls, then sample 1 time unit after the edge.
    task automatic cyc(input logic l, input logic s, input logic c, input logic r,
                       input logic [DW-1:0] d, input logic [DW*DP-1:0] pd);
        ld        = l;
        shift_en  = s;
        clrh      = c;
`ifdef CONV_TAPLINE_ROTATE_EN
        rot_en    = r;
`else
        if (r) $display("note: rotate request ignored in linear build");
`endif
        data_i    = d;
        ld_data_i = pd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0; ld = 1'b0; shift_en = 1'b0; clrh = 1'b0;
`ifdef CONV_TAPLINE_ROTATE_EN
        rot_en = 1'b0;
`endif
        data_i = '0; ld_data_i = '0;
        #3;
        chk("rst_taps",  32'(taps_o),  32'h0);
        chk("rst_count", 32'(count_o), 32'h0);
        chk("rst_full",  32'(full_o),  32'h0);
        chk("rst_valid", 32'(valid_o), 32'h0);
        @(negedge clk) rstn = 1'b1;

        // Async reset mid-stream
        cyc(1, 0, 0, 0, 8'h00, 24'h332211);
        chk("ld_taps",  32'(taps_o), 32'h332211);
        chk("ld_valid", 32'(valid_o), 32'h1);
        rstn = 1'b0;
        #1;
        chk("arst_taps",  32'(taps_o),  32'h0);
        chk("arst_count", 32'(count_o), 32'h0);
        chk("arst_full",  32'(full_o),  32'h0);
        chk("arst_valid", 32'(valid_o), 32'h0);
        @(negedge clk) rstn = 1'b1;

        // Fill
        cyc(0, 1, 0, 0, 8'hA1, 24'h0);
        chk("fill1_count", 32'(count_o), 32'd1);
        chk("fill1_valid", 32'(valid_o), 32'h0);
        cyc(0, 1, 0, 0, 8'hB2, 24'h0);
        chk("fill2_count", 32'(count_o), 32'd2);
        chk("fill2_valid", 32'(valid_o), 32'h0);
        chk("fill2_full",  32'(full_o),  32'h0);
        cyc(0, 1, 0, 0, 8'hC3, 24'h0);
        chk("fill3_count", 32'(count_o), 32'd3);
        chk("fill3_valid", 32'(valid_o), 32'h1);
        chk("fill3_full",  32'(full_o),  32'h1);
        chk("fill3_taps",  32'(taps_o),  32'hA1B2C3);
        chk("fill3_data",  32'(data_o),  32'hA1);
        cyc(0, 1, 0, 0, 8'hD4, 24'h0);
        chk("sat_count", 32'(count_o), 32'd3);
        chk("sat_valid", 32'(valid_o), 32'h1);
        chk("sat_data",  32'(data_o),  32'hB2);
        chk("sat_taps",  32'(taps_o),  32'hB2C3D4);

        // Hold
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 8'hEE, 24'h0);
            chk("hold_taps",  32'(taps_o),  32'hB2C3D4);
            chk("hold_valid", 32'(valid_o), 32'h0);
        end
        chk("hold_count", 32'(count_o), 32'd3);

        // ld beats shift and clear
        cyc(1, 1, 1, 0, 8'h77, 24'h030201);
        chk("prio_taps",  32'(taps_o),  32'h030201);
        chk("prio_count", 32'(count_o), 32'd3);
        chk("prio_valid", 32'(valid_o), 32'h1);

`ifdef CONV_TAPLINE_ROTATE_EN
        cyc(1, 0, 0, 0, 8'h00, 24'hA1B2C3);
        cyc(0, 1, 0, 1, 8'hFF, 24'h0);
        chk("rot_taps",  32'(taps_o),  32'hB2C3A1);
        chk("rot_count", 32'(count_o), 32'd3);
        chk("rot_valid", 32'(valid_o), 32'h1);
        cyc(1, 0, 0, 0, 8'h00, 24'h030201);
`endif

        // Shift beats clear, then clear alone
        cyc(0, 1, 1, 0, 8'h55, 24'h0);
        chk("shclr_taps",  32'(taps_o),  32'h020155);
        chk("shclr_count", 32'(count_o), 32'd3);
        cyc(0, 0, 1, 0, 8'h66, 24'h0);
        chk("clr_taps",  32'(taps_o),  32'h0);
        chk("clr_count", 32'(count_o), 32'd0);
        chk("clr_full",  32'(full_o),  32'h0);
        chk("clr_valid", 32'(valid_o), 32'h0);

        // Partial refill after clear
        cyc(0, 1, 0, 0, 8'h9A, 24'h0);
        chk("refill_count", 32'(count_o), 32'd1);
        chk("refill_valid", 32'(valid_o), 32'h0);
        chk("refill_taps",  32'(taps_o),  32'h00009A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
